// File: rtl/gfx_pixel_fader.sv
// rtl/gfx_pixel_fader.sv - per-channel pixel fade stage with change flag and frame cadence
module gfx_pixel_fader #(
  parameter int NUM_CH      = 3,
  parameter int CH_BITS     = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int PERIOD_BITS = 4,
  parameter int CNT_BITS    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   cfg_mode,
  input  logic [CH_BITS-1:0]           cfg_step,
  input  logic [PERIOD_BITS-1:0]       cfg_period,
  input  logic                         frame_start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic [NUM_CH*CH_BITS-1:0]    in_color,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [NUM_CH*CH_BITS-1:0]    out_color,
  output logic                         out_changed,
  output logic                         fade_active,
  output logic [CNT_BITS-1:0]          last_nonzero
);

  localparam int PIXEL_BITS = NUM_CH * CH_BITS;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_SUB    = 2'd1;
  localparam logic [1:0] MODE_HALF   = 2'd2;
  localparam logic [1:0] MODE_CLEAR  = 2'd3;

  localparam logic [PERIOD_BITS:0] FC_ONE  = (PERIOD_BITS + 1)'(1);
  localparam logic [CNT_BITS-1:0]  CNT_ONE = CNT_BITS'(1);

  // Frame cadence and shadow configuration
  logic [PERIOD_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic                   fade_q, fade_d;
  logic [1:0]             mode_q, mode_d;
  logic [CH_BITS-1:0]     step_q, step_d;

  // Pipeline stages
  logic                   s1_v_q, s1_v_d;
  logic [ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d;
  logic [PIXEL_BITS-1:0]  s1_color_q, s1_color_d;
  logic                   s1_fade_q, s1_fade_d;
  logic [1:0]             s1_mode_q, s1_mode_d;
  logic [CH_BITS-1:0]     s1_step_q, s1_step_d;

  logic                   s2_v_q, s2_v_d;
  logic [ADDR_WIDTH-1:0]  s2_addr_q, s2_addr_d;
  logic [PIXEL_BITS-1:0]  s2_color_q, s2_color_d;
  logic                   s2_changed_q, s2_changed_d;

  // Statistics
  logic [CNT_BITS-1:0]    nz_cnt_q, nz_cnt_d;
  logic [CNT_BITS-1:0]    last_nz_q, last_nz_d;

  logic                   s2_adv;
  logic                   s1_adv;
  logic [PERIOD_BITS-1:0] eff_now;
  logic [PERIOD_BITS:0]   cnt_inc;
  logic [PIXEL_BITS-1:0]  faded;
  logic [CH_BITS-1:0]     ch;
  logic [CH_BITS-1:0]     res;
  logic [CH_BITS:0]       diff;
  logic [CNT_BITS-1:0]    nz_inc;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = !reset && s1_adv;

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    period_d     = period_q;
    fade_d       = fade_q;
    mode_d       = mode_q;
    step_d       = step_q;
    s1_v_d       = s1_v_q;
    s1_addr_d    = s1_addr_q;
    s1_color_d   = s1_color_q;
    s1_fade_d    = s1_fade_q;
    s1_mode_d    = s1_mode_q;
    s1_step_d    = s1_step_q;
    s2_v_d       = s2_v_q;
    s2_addr_d    = s2_addr_q;
    s2_color_d   = s2_color_q;
    s2_changed_d = s2_changed_q;
    nz_cnt_d     = nz_cnt_q;
    last_nz_d    = last_nz_q;
    faded        = s1_color_q;
    ch           = '0;
    res          = '0;
    diff         = '0;
    nz_inc       = nz_cnt_q;

    eff_now = cfg_period;
    if (cfg_period == '0) begin
      eff_now    = '0;
      eff_now[0] = 1'b1;
    end
    cnt_inc = {1'b0, frame_cnt_q} + FC_ONE;

    if (frame_start) begin
      mode_d   = cfg_mode;
      step_d   = cfg_step;
      period_d = eff_now;
      if (cnt_inc >= {1'b0, period_d}) begin
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = cnt_inc[PERIOD_BITS-1:0];
      end
      fade_d = (frame_cnt_d == '0);
    end

    // Tag with next-state cadence so a pixel on the frame_start cycle joins the new frame
    if (s1_adv) begin
      s1_v_d     = in_valid;
      s1_addr_d  = in_addr;
      s1_color_d = in_color;
      s1_fade_d  = fade_d;
      s1_mode_d  = mode_d;
      s1_step_d  = step_d;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      ch   = s1_color_q[i*CH_BITS +: CH_BITS];
      diff = {1'b0, ch} - {1'b0, s1_step_q};
      case (s1_mode_q)
        MODE_BYPASS: res = ch;
        MODE_SUB:    res = diff[CH_BITS] ? '0 : diff[CH_BITS-1:0];
        MODE_HALF:   res = ch >> 1;
        MODE_CLEAR:  res = '0;
      endcase
      if (s1_fade_q) begin
        faded[i*CH_BITS +: CH_BITS] = res;
      end
    end

    if (s2_adv) begin
      s2_v_d       = s1_v_q;
      s2_addr_d    = s1_addr_q;
      s2_color_d   = faded;
      s2_changed_d = (faded != s1_color_q);
    end

    if (s2_v_q && out_ready && (s2_color_q != '0) && (nz_cnt_q != '1)) begin
      nz_inc = nz_cnt_q + CNT_ONE;
    end
    if (frame_start) begin
      last_nz_d = nz_inc;
      nz_cnt_d  = '0;
    end else begin
      nz_cnt_d  = nz_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      period_q     <= '0;
      fade_q       <= 1'b0;
      mode_q       <= '0;
      step_q       <= '0;
      s1_v_q       <= 1'b0;
      s1_addr_q    <= '0;
      s1_color_q   <= '0;
      s1_fade_q    <= 1'b0;
      s1_mode_q    <= '0;
      s1_step_q    <= '0;
      s2_v_q       <= 1'b0;
      s2_addr_q    <= '0;
      s2_color_q   <= '0;
      s2_changed_q <= 1'b0;
      nz_cnt_q     <= '0;
      last_nz_q    <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      period_q     <= period_d;
      fade_q       <= fade_d;
      mode_q       <= mode_d;
      step_q       <= step_d;
      s1_v_q       <= s1_v_d;
      s1_addr_q    <= s1_addr_d;
      s1_color_q   <= s1_color_d;
      s1_fade_q    <= s1_fade_d;
      s1_mode_q    <= s1_mode_d;
      s1_step_q    <= s1_step_d;
      s2_v_q       <= s2_v_d;
      s2_addr_q    <= s2_addr_d;
      s2_color_q   <= s2_color_d;
      s2_changed_q <= s2_changed_d;
      nz_cnt_q     <= nz_cnt_d;
      last_nz_q    <= last_nz_d;
    end
  end

  assign out_valid    = s2_v_q;
  assign out_addr     = s2_addr_q;
  assign out_color    = s2_color_q;
  assign out_changed  = s2_changed_q;
  assign fade_active  = fade_q;
  assign last_nonzero = last_nz_q;

endmodule

// File: tb/tb_gfx_pixel_fader.sv
// tb/tb_gfx_pixel_fader.sv - directed self-checking bench for gfx_pixel_fader
module tb_gfx_pixel_fader;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_step;
  logic [3:0]  cfg_period;
  logic        frame_start;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_addr;
  logic [11:0] in_color;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_addr;
  logic [11:0] out_color;
  logic        out_changed;
  logic        fade_active;
  logic [15:0] last_nonzero;

  int n_cmp = 0;
  int n_bad = 0;

  gfx_pixel_fader dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_mode     (cfg_mode),
    .cfg_step     (cfg_step),
    .cfg_period   (cfg_period),
    .frame_start  (frame_start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_color     (in_color),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_color    (out_color),
    .out_changed  (out_changed),
    .fade_active  (fade_active),
    .last_nonzero (last_nonzero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_frame;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
  endtask

  // Push one pixel into an empty pipe and check the result two cycles later
  task automatic push_chk(input string tag, input logic [9:0] a, input logic [11:0] c,
                          input logic [11:0] ec, input logic ech);
    in_valid = 1'b1;
    in_addr  = a;
    in_color = c;
    tick;
    in_valid = 1'b0;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    tick;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_addr"}, 32'(out_addr), 32'(a));
    check({tag, "_color"}, 32'(out_color), 32'(ec));
    check({tag, "_changed"}, 32'(out_changed), 32'(ech));
    tick;
  endtask

  initial begin
    int sent;
    int recv;
    int stalls;
    logic [11:0] col;

    reset = 1'b1; cfg_mode = 2'd0; cfg_step = 4'd0; cfg_period = 4'd1;
    frame_start = 1'b0; in_valid = 1'b0; in_addr = '0; in_color = '0; out_ready = 1'b1;
    tick;
    tick;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fade", 32'(fade_active), 32'd0);
    check("rst_last_nz", 32'(last_nonzero), 32'd0);
    check("rst_out_color", 32'(out_color), 32'd0);
    reset = 1'b0;
    tick;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    push_chk("bypass_abc", 10'd5, 12'hABC, 12'hABC, 1'b0);

    // Output held stable under backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 10'd9; in_color = 12'h321;
    tick;
    in_valid = 1'b0;
    tick; tick;
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_color", 32'(out_color), 32'h321);
    tick;
    check("stall_hold_addr", 32'(out_addr), 32'd9);
    check("stall_hold_color", 32'(out_color), 32'h321);
    out_ready = 1'b1;
    tick;
    check("stall_drained", 32'(out_valid), 32'd0);

    cfg_mode = 2'd1; cfg_step = 4'd3; cfg_period = 4'd1;
    pulse_frame;
    check("sub_fade_active", 32'(fade_active), 32'd1);
    push_chk("sub_5a2", 10'd1, 12'h5A2, 12'h270, 1'b1);
    push_chk("sub_000", 10'd2, 12'h000, 12'h000, 1'b0);

    cfg_mode = 2'd2;
    pulse_frame;
    push_chk("half_f81", 10'd3, 12'hF81, 12'h740, 1'b1);
    cfg_mode = 2'd3;
    pulse_frame;
    push_chk("clear_123", 10'd4, 12'h123, 12'h000, 1'b1);
    cfg_mode = 2'd0;
    push_chk("cfg_no_effect", 10'd4, 12'h123, 12'h000, 1'b1);

    cfg_mode = 2'd1; cfg_step = 4'd1; cfg_period = 4'd2;
    for (int f = 0; f < 4; f++) begin
      pulse_frame;
      check($sformatf("period2_fade_f%0d", f), 32'(fade_active), 32'(f % 2));
      push_chk($sformatf("period2_px_f%0d", f), 10'(f), 12'h888,
               (f % 2 == 1) ? 12'h777 : 12'h888, (f % 2 == 1));
    end

    cfg_period = 4'd0;
    pulse_frame;
    check("period0_fade_a", 32'(fade_active), 32'd1);
    pulse_frame;
    check("period0_fade_b", 32'(fade_active), 32'd1);

    cfg_period = 4'd2;
    frame_start = 1'b1;
    tick;
    tick;
    frame_start = 1'b0;
    check("b2b_frames_fade", 32'(fade_active), 32'd1);
    pulse_frame;
    check("single_frame_fade", 32'(fade_active), 32'd0);

    // Pixel accepted together with frame_start takes the new frame's fade tag
    frame_start = 1'b1;
    in_valid = 1'b1; in_addr = 10'd3; in_color = 12'h888;
    tick;
    frame_start = 1'b0; in_valid = 1'b0;
    tick;
    check("fs_px_valid", 32'(out_valid), 32'd1);
    check("fs_px_color", 32'(out_color), 32'h777);
    tick;

    cfg_mode = 2'd0;
    pulse_frame;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 2000 && recv < 128; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 128);
      in_addr   = 10'(sent);
      col       = 12'((sent * 37 + 5) & 12'hFFF);
      in_color  = col;
      #2;
      if (out_valid && out_ready) begin
        col = 12'((recv * 37 + 5) & 12'hFFF);
        check($sformatf("stream_px%0d", recv), {10'd0, out_addr, out_color},
              {10'd0, 10'(recv), col});
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", 32'(recv), 32'd128);
    tick; tick;
    check("stream_no_extra", 32'(out_valid), 32'd0);

    stalls = 0; recv = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 16);
      in_addr  = 10'(i);
      in_color = 12'(i + 1);
      #2;
      if (in_valid && !in_ready) stalls++;
      if (out_valid) recv++;
      tick;
    end
    in_valid = 1'b0;
    check("fullrate_stalls", 32'(stalls), 32'd0);
    check("fullrate_count", 32'(recv), 32'd16);

    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    pulse_frame;
    check("stats_initial", 32'(last_nonzero), 32'd0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_addr  = 10'(i);
      in_color = (i % 3 == 0) ? 12'h000 : 12'(i * 12'h101);
      tick;
    end
    in_valid = 1'b0;
    tick; tick; tick;
    pulse_frame;
    check("stats_last_nz6", 32'(last_nonzero), 32'd6);

    // Handshake on the frame_start cycle still counts for the closing frame
    in_valid = 1'b1; in_addr = 10'd1; in_color = 12'h111;
    tick;
    in_valid = 1'b0;
    tick;
    check("coincide_valid", 32'(out_valid), 32'd1);
    pulse_frame;
    check("coincide_last_nz", 32'(last_nonzero), 32'd1);

    in_valid = 1'b1; in_addr = 10'd2; in_color = 12'h222;
    tick;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    tick;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_last_nz", 32'(last_nonzero), 32'd0);
    reset = 1'b0;
    tick; tick;
    check("midrst_dropped", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
